// File: rtl/hub75_fetchshift.sv
// hub75_fetchshift: fetches one scan row per start pulse and shifts the selected bit plane
// into the HUB75 column drivers, paced by display_clk.
module hub75_fetchshift #(
    parameter int ROWS   = 64,
    parameter int COLS   = 64,
    parameter int ADDR_W = 12
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              display_clk,
    input  logic              fetchshift_start,
    input  logic              seq_rst,
    output logic              fetchshift_busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [47:0]       rd_data,
    output logic              r0,
    output logic              g0,
    output logic              b0,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic              sclk
);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, CLK_LO, CLK_HI, DONE} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     row, row_use;
    logic [CW-1:0]     col, col_nxt;
    logic [2:0]        plane;
    logic              pending;
    logic [ADDR_W-1:0] addr_nxt;
    logic              last_col, last_row;

    assign last_col = col == CW'(COLS - 1);
    assign last_row = row == RW'(ROWS - 1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            fetchshift_busy <= 1'b0;
            sclk            <= 1'b0;
            rd_addr         <= '0;
            col             <= '0;
        end else begin
            state           <= state_nxt;
            fetchshift_busy <= state_nxt != IDLE;
            sclk            <= state_nxt == CLK_HI;
            rd_addr         <= addr_nxt;
            col             <= col_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fetchshift_start ? ADDR : IDLE;
            ADDR:    state_nxt = WAIT;
            WAIT:    state_nxt = CLK_LO;
            CLK_LO:  state_nxt = display_clk ? CLK_HI : CLK_LO;
            CLK_HI:  state_nxt = !display_clk ? CLK_HI : last_col ? DONE : ADDR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A seq_rst arriving with start in IDLE must already steer the first address to row 0.
    always_comb begin
        col_nxt  = state == IDLE ? '0 : (state == CLK_HI && display_clk && !last_col) ? col + 1'b1 : col;
        row_use  = (state == IDLE && seq_rst) ? '0 : row;
        addr_nxt = state_nxt == ADDR ? ADDR_W'(row_use) * ADDR_W'(COLS) + ADDR_W'(col_nxt) : rd_addr;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            plane   <= '0;
            pending <= 1'b0;
        end else if (state == IDLE && seq_rst) begin
            row   <= '0;
            plane <= '0;
        end else if (state == DONE) begin
            pending <= 1'b0;
            if (pending || seq_rst) begin
                row   <= '0;
                plane <= '0;
            end else begin
                plane <= plane + 3'd1;
                if (plane == 3'd7) row <= last_row ? '0 : row + 1'b1;
            end
        end else if (seq_rst && state != IDLE) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            {b1, g1, r1, b0, g0, r0} <= '0;
        end else if (state == WAIT) begin
            r0 <= rd_data[{3'd0, plane}];
            g0 <= rd_data[{3'd1, plane}];
            b0 <= rd_data[{3'd2, plane}];
            r1 <= rd_data[{3'd3, plane}];
            g1 <= rd_data[{3'd4, plane}];
            b1 <= rd_data[{3'd5, plane}];
        end
    end
endmodule

// File: tb/tb_hub75_fetchshift.sv
// tb_hub75_fetchshift: directed stimulus with a pixel/transfer scoreboard checked by a
// negedge monitor against a small frame-buffer model.
module tb_hub75_fetchshift;
    localparam int ROWS = 4, COLS = 4, ADDR_W = 4;

    logic sys_clk = 0, rst_n = 0, display_clk = 1, start = 0, seq_rst = 0;
    logic busy, sclk, r0, g0, b0, r1, g1, b1;
    logic [ADDR_W-1:0] rd_addr;
    logic [47:0] rd_data;
    logic [5:0] rgb;
    logic [47:0] mem [16];

    int checks = 0, errors = 0;
    logic [9:0] pix_q[$];
    int len_q[$];
    int m_row = 0, m_plane = 0;
    bit mon_en = 0;
    logic sclk_q = 0, busy_q = 0;
    int bcnt = 0, npix = 0, l;
    logic [9:0] e;
    logic [ADDR_W-1:0] first_addr = '0;
    logic [5:0] e0;

    hub75_fetchshift #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .display_clk(display_clk),
        .fetchshift_start(start), .seq_rst(seq_rst), .fetchshift_busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1), .sclk(sclk)
    );

    assign rgb = {b1, g1, r1, b0, g0, r0};

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) rd_data <= mem[rd_addr];

    function automatic logic [5:0] pick(input logic [47:0] d, input int p);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = d[8*k+p];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (sclk && !sclk_q) begin
                if (npix == 0) first_addr = rd_addr;
                npix++;
                if (pix_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected sclk pulse: addr %0h rgb %0h, none expected", rd_addr, rgb);
                end else begin
                    e = pix_q.pop_front();
                    chk("pixel {addr,rgb}", {54'd0, rd_addr, rgb}, {54'd0, e});
                end
            end
            if (busy) bcnt++;
            if (!busy && busy_q) begin
                if (len_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected transfer: %0d busy cycles, none expected", bcnt);
                end else begin
                    l = len_q.pop_front();
                    if (l != 0) chk("busy cycles", 64'(bcnt), 64'(l));
                    chk("sclk pulses", 64'(npix), 64'(COLS));
                end
                bcnt = 0;
                npix = 0;
            end
        end else begin
            bcnt = 0;
            npix = 0;
        end
        sclk_q = sclk;
        busy_q = busy;
    end

    task automatic push_xfer(input int len);
        for (int c = 0; c < COLS; c++) begin
            int a = m_row * COLS + c;
            pix_q.push_back({4'(a), pick(mem[a], m_plane)});
        end
        len_q.push_back(len);
        if (m_plane == 7) begin
            m_plane = 0;
            m_row = (m_row + 1) % ROWS;
        end else m_plane++;
    endtask

    task automatic go();
        start = 1;
        @(negedge sys_clk);
        start = 0;
        chk("busy one cycle after start", 64'(busy), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge sys_clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle timeout: busy still 1 after %0d cycles, required 0", n);
        end
        @(negedge sys_clk);
    endtask

    task automatic xfer();
        push_xfer(17);
        go();
        wait_idle();
    endtask

    task automatic seq_clear();
        seq_rst = 1;
        @(negedge sys_clk);
        seq_rst = 0;
        m_row = 0;
        m_plane = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = '0;
        mem[1] = 48'hFFFF_FFFF_FFFF;
        repeat (2) @(negedge sys_clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset sclk", 64'(sclk), 64'd0);
        chk("reset rd_addr", 64'(rd_addr), 64'd0);
        chk("reset rgb", 64'(rgb), 64'd0);
        rst_n = 1;
        mon_en = 1;
        @(negedge sys_clk);

        // single transfer: only column 1 lit, 17 busy cycles
        xfer();
        chk("single first addr", 64'(first_addr), 64'd0);

        for (int a = 0; a < 16; a++) mem[a] = 48'h5A3C_96E1_0FF0 ^ {12{4'(a)}};
        seq_clear();

        // full frame of planes and rows, then wrap
        for (int i = 0; i < 33; i++) begin
            xfer();
            if (i == 8) chk("row1 plane0 first addr", 64'(first_addr), 64'd4);
            if (i == 31) chk("row3 plane7 first addr", 64'(first_addr), 64'd12);
            if (i == 32) chk("wrap first addr", 64'(first_addr), 64'd0);
        end

        // pacing stall in CLK_LO
        e0 = pick(mem[m_row * COLS], m_plane);
        push_xfer(0);
        display_clk = 0;
        go();
        repeat (20) @(negedge sys_clk);
        chk("stall sclk low", 64'(sclk), 64'd0);
        chk("stall busy", 64'(busy), 64'd1);
        chk("stall rgb held", 64'(rgb), 64'(e0));
        display_clk = 1;
        @(negedge sys_clk);
        display_clk = 0;
        chk("sclk rises on pulse", 64'(sclk), 64'd1);
        @(negedge sys_clk);
        chk("sclk held in CLK_HI", 64'(sclk), 64'd1);
        display_clk = 1;
        wait_idle();

        // start ignored in ADDR, CLK_HI and DONE
        push_xfer(17);
        go();
        start = 1;
        @(negedge sys_clk);
        start = 0;
        repeat (2) @(negedge sys_clk);
        chk("in CLK_HI", 64'(sclk), 64'd1);
        start = 1;
        @(negedge sys_clk);
        start = 0;
        repeat (12) @(negedge sys_clk);
        chk("in DONE busy", 64'(busy), 64'd1);
        chk("in DONE sclk", 64'(sclk), 64'd0);
        start = 1;
        @(negedge sys_clk);
        start = 0;
        chk("idle after DONE start", 64'(busy), 64'd0);
        repeat (3) @(negedge sys_clk);
        chk("no queued transfer", 64'(busy), 64'd0);

        // seq_rst mid-transfer at row 2 plane 5
        seq_clear();
        for (int i = 0; i < 21; i++) xfer();
        push_xfer(17);
        m_row = 0;
        m_plane = 0;
        go();
        repeat (5) @(negedge sys_clk);
        seq_rst = 1;
        @(negedge sys_clk);
        seq_rst = 0;
        wait_idle();
        chk("seq_rst in-flight first addr", 64'(first_addr), 64'd8);
        xfer();
        chk("after seq_rst first addr", 64'(first_addr), 64'd0);

        // seq_rst and start together in IDLE
        xfer();
        m_row = 0;
        m_plane = 0;
        push_xfer(17);
        start = 1;
        seq_rst = 1;
        @(negedge sys_clk);
        start = 0;
        seq_rst = 0;
        chk("busy after start+seq_rst", 64'(busy), 64'd1);
        wait_idle();
        chk("start+seq_rst first addr", 64'(first_addr), 64'd0);

        // async reset in CLK_HI of column 2
        mon_en = 0;
        start = 1;
        @(negedge sys_clk);
        start = 0;
        repeat (11) @(negedge sys_clk);
        chk("pre-reset sclk", 64'(sclk), 64'd1);
        chk("pre-reset rd_addr", 64'(rd_addr), 64'd2);
        rst_n = 0;
        #1;
        chk("async reset sclk", 64'(sclk), 64'd0);
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset rgb", 64'(rgb), 64'd0);
        chk("async reset rd_addr", 64'(rd_addr), 64'd0);
        @(negedge sys_clk);
        rst_n = 1;
        repeat (2) @(negedge sys_clk);
        chk("post-reset busy", 64'(busy), 64'd0);
        chk("post-reset sclk", 64'(sclk), 64'd0);
        m_row = 0;
        m_plane = 0;
        mon_en = 1;
        xfer();
        chk("post-reset first addr", 64'(first_addr), 64'd0);

        chk("pixel queue drained", 64'(pix_q.size()), 64'd0);
        chk("transfer queue drained", 64'(len_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
